// File: rtl/icache_axi_fetch_pkg.sv
// Shared types and AXI constants for the instruction-cache fetch path.
// Optional feature macro used by the top: ICF_PERF_EN.
package icache_axi_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } icf_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_ICF  = 4'b0011;
  localparam logic [2:0] AXI_PROT_ICF   = 3'b100;

endpackage

// File: rtl/icache_axi_fetch_line_store.sv
// Valid/tag/data arrays of the direct-mapped icache: async read, sync write.
// Only the valid bits are reset; tag and data contents survive reset.
module icf_line_store #(
  parameter int LINES      = 16,
  parameter int WORDS      = 4,
  parameter int TAG_W      = 24,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(LINES)-1:0]   rd_index,
  input  logic [$clog2(WORDS)-1:0]   rd_offset,
  output logic                       rd_valid,
  output logic [TAG_W-1:0]           rd_tag,
  output logic [DATA_WIDTH-1:0]      rd_data,
  input  logic                       wr_en,
  input  logic [$clog2(LINES)-1:0]   wr_index,
  input  logic [$clog2(WORDS)-1:0]   wr_offset,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       commit,
  input  logic                       commit_valid,
  input  logic [TAG_W-1:0]           commit_tag
);

  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [DATA_WIDTH-1:0] r_data [LINES][WORDS];

  // A failed fill clears the line so partially overwritten data is never hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (commit) begin
      r_valid[wr_index] <= commit_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      r_tag[wr_index] <= commit_tag;
    end
    if (wr_en) begin
      r_data[wr_index][wr_offset] <= wr_data;
    end
  end

  assign rd_valid = r_valid[rd_index];
  assign rd_tag   = r_tag[rd_index];
  assign rd_data  = r_data[rd_index][rd_offset];

endmodule

// File: rtl/icache_axi_fetch.sv
// Direct-mapped read-only icache with single-burst AXI4 line fill.
// Define ICF_PERF_EN to add hit_cnt/miss_cnt performance counters.
module icache_axi_fetch
  import icache_axi_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 16,
  parameter int WORDS      = 4
) (
  input  logic                  Clk,
  input  logic                  Rstn,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  miss,
  output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
  output logic [7:0]            m00_axi_arlen,
  output logic [2:0]            m00_axi_arsize,
  output logic [1:0]            m00_axi_arburst,
  output logic                  m00_axi_arvalid,
  input  logic                  m00_axi_arready,
  output logic                  m00_axi_arid,
  output logic                  m00_axi_arlock,
  output logic [3:0]            m00_axi_arcache,
  output logic [2:0]            m00_axi_arprot,
  output logic [3:0]            m00_axi_arqos,
  input  logic [DATA_WIDTH-1:0] m00_axi_rdata,
  input  logic [1:0]            m00_axi_rresp,
  input  logic                  m00_axi_rlast,
  input  logic                  m00_axi_rvalid,
  output logic                  m00_axi_rready
`ifdef ICF_PERF_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;

  icf_state_t r_state, w_state_nxt;

  logic [TAG_W-1:0]      w_tag, w_line_tag, r_fill_tag;
  logic [IDX_W-1:0]      w_index, r_fill_index;
  logic [OFF_W-1:0]      w_offset, r_beat_cnt;
  logic                  w_line_valid, w_hit, w_lookup_miss;
  logic                  w_beat, w_commit, w_fill_ok, r_resp_ok;
  logic [DATA_WIDTH-1:0] w_line_data;
  logic                  w_unused;

  assign w_offset = addr[OFF_W+1:2];
  assign w_index  = addr[IDX_W+OFF_W+1:OFF_W+2];
  assign w_tag    = addr[ADDR_WIDTH-1:IDX_W+OFF_W+2];
  assign w_unused = &{1'b0, addr[1:0]};

  assign w_hit         = (r_state == ST_IDLE) && w_line_valid && (w_line_tag == w_tag);
  assign w_lookup_miss = (r_state == ST_IDLE) && !w_hit;
  assign w_beat        = (r_state == ST_R) && m00_axi_rvalid;
  assign w_commit      = w_beat && m00_axi_rlast;
  assign w_fill_ok     = r_resp_ok && (m00_axi_rresp == AXI_RESP_OKAY);

  assign miss = !w_hit;
  assign data = w_line_data;

  icf_line_store #(
    .LINES      (LINES),
    .WORDS      (WORDS),
    .TAG_W      (TAG_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_line_store (
    .clk          (Clk),
    .rst_n        (Rstn),
    .rd_index     (w_index),
    .rd_offset    (w_offset),
    .rd_valid     (w_line_valid),
    .rd_tag       (w_line_tag),
    .rd_data      (w_line_data),
    .wr_en        (w_beat),
    .wr_index     (r_fill_index),
    .wr_offset    (r_beat_cnt),
    .wr_data      (m00_axi_rdata),
    .commit       (w_commit),
    .commit_valid (w_fill_ok),
    .commit_tag   (r_fill_tag)
  );

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    m00_axi_arvalid = 1'b0;
    m00_axi_rready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_lookup_miss) begin
          w_state_nxt = ST_AR;
        end
      end
      ST_AR: begin
        m00_axi_arvalid = 1'b1;
        if (m00_axi_arready) begin
          w_state_nxt = ST_R;
        end
      end
      ST_R: begin
        m00_axi_rready = 1'b1;
        if (m00_axi_rvalid && m00_axi_rlast) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // rlast alone ends the fill; the beat counter simply wraps if the slave miscounts.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      r_fill_tag   <= '0;
      r_fill_index <= '0;
      r_beat_cnt   <= '0;
      r_resp_ok    <= 1'b1;
    end else begin
      if (w_lookup_miss) begin
        r_fill_tag   <= w_tag;
        r_fill_index <= w_index;
      end
      if (r_state == ST_AR) begin
        r_beat_cnt <= '0;
        r_resp_ok  <= 1'b1;
      end
      if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
        if (m00_axi_rresp != AXI_RESP_OKAY) begin
          r_resp_ok <= 1'b0;
        end
      end
    end
  end

  assign m00_axi_araddr  = {r_fill_tag, r_fill_index, {(OFF_W+2){1'b0}}};
  assign m00_axi_arlen   = 8'(WORDS - 1);
  assign m00_axi_arsize  = AXI_SIZE_4B;
  assign m00_axi_arburst = AXI_BURST_INCR;
  assign m00_axi_arid    = 1'b0;
  assign m00_axi_arlock  = 1'b0;
  assign m00_axi_arcache = AXI_CACHE_ICF;
  assign m00_axi_arprot  = AXI_PROT_ICF;
  assign m00_axi_arqos   = '0;

`ifdef ICF_PERF_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_lookup_miss) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
